// File: rtl/exu.sv
// -----------------------------------------------------------------------------
// exu -- small integer execution unit with an architectural register file,
// a single-cycle ALU and an optional iterative shift-add multiplier.
//
// Optional feature macro: EXU_MUL_EN
//   defined   : opcode 13 (MUL) runs a DW-cycle shift-add multiply (IDLE->MUL)
//   undefined : opcode 13 behaves as NOP, op_ready only follows rst_n
//
// Ports
//   clk        in   sole clock, all state on the rising edge
//   rst_n      in   synchronous active-low reset
//   op_valid   in   micro-op present
//   op_ready   out  unit can accept (accept = op_valid && op_ready)
//   op_code    in   [3:0] operation select
//   op_rd      in   [AW-1:0] destination / first operand register
//   op_rs      in   [AW-1:0] second operand register
//   op_imm     in   [DW-1:0] immediate
//   op_use_imm in   second operand is op_imm instead of reg[op_rs]
//   res_valid  out  one-cycle result strobe
//   res_data   out  [DW-1:0] result
//   res_rd     out  [AW-1:0] destination index of the result
//   flags      out  [3:0] {V,C,N,Z}
// -----------------------------------------------------------------------------
module exu #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    op_code,
  input  logic [AW-1:0] op_rd,
  input  logic [AW-1:0] op_rs,
  input  logic [DW-1:0] op_imm,
  input  logic          op_use_imm,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [AW-1:0] res_rd,
  output logic [3:0]    flags
);

  // flag bit positions inside {V,C,N,Z}
  localparam int FV = 3;
  localparam int FC = 2;

  logic [DW-1:0] reg_file [NREG];
  logic [3:0]    flags_reg;
  logic          res_valid_reg;
  logic [DW-1:0] res_data_reg;
  logic [AW-1:0] res_rd_reg;

  logic          accept;
  logic [DW-1:0] a_val;
  logic [DW-1:0] b_val;
  logic [3:0]    sh_amt;

  logic [DW:0]   add_ext;
  logic [DW:0]   sub_ext;
  logic [DW:0]   shl_ext;
  logic [DW:0]   shr_ext;
  logic [DW:0]   sar_ext;

  logic [DW-1:0] alu_res;
  logic [3:0]    alu_flags;
  logic          alu_wr;
  logic          alu_fl;
  logic          c_new;
  logic          v_new;
  logic          mul_start;

  logic          mul_done;
  logic [DW-1:0] mul_final;
  logic [AW-1:0] mul_rd;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data;

  assign accept = op_valid && op_ready;

  // r0 is hard-wired to zero on the read side as well as never written
  assign a_val  = (op_rd == '0) ? '0 : reg_file[op_rd];
  assign b_val  = op_use_imm ? op_imm : ((op_rs == '0) ? '0 : reg_file[op_rs]);
  assign sh_amt = b_val[3:0];

  // Carry-in only participates for ADC / SBC. Subtraction in DW+1 bits
  // leaves the borrow in the top bit.
  assign add_ext = {1'b0, a_val} + {1'b0, b_val}
                 + {{DW{1'b0}}, (op_code == 4'd2) & flags_reg[FC]};
  assign sub_ext = {1'b0, a_val} - {1'b0, b_val}
                 - {{DW{1'b0}}, (op_code == 4'd4) & flags_reg[FC]};

  // Shifts are done one bit wider so the last bit shifted out lands in the
  // extra bit; a zero shift amount naturally yields C=0.
  assign shl_ext = {1'b0, a_val} << sh_amt;
  assign shr_ext = {a_val, 1'b0} >> sh_amt;
  assign sar_ext = $unsigned($signed({a_val, 1'b0}) >>> sh_amt);

  always_comb begin
    alu_res   = '0;
    alu_wr    = 1'b0;
    alu_fl    = 1'b0;
    c_new     = 1'b0;
    v_new     = 1'b0;
    mul_start = 1'b0;
    case (op_code)
      4'd0: begin
        alu_res = b_val;
        alu_wr  = 1'b1;
      end
      4'd1, 4'd2: begin
        alu_res = add_ext[DW-1:0];
        c_new   = add_ext[DW];
        v_new   = (a_val[DW-1] == b_val[DW-1]) && (add_ext[DW-1] != a_val[DW-1]);
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      4'd3, 4'd4, 4'd12: begin
        alu_res = sub_ext[DW-1:0];
        c_new   = sub_ext[DW];
        v_new   = (a_val[DW-1] != b_val[DW-1]) && (sub_ext[DW-1] != a_val[DW-1]);
        alu_wr  = (op_code != 4'd12);
        alu_fl  = 1'b1;
      end
      4'd5: begin alu_res = a_val & b_val; alu_wr = 1'b1; alu_fl = 1'b1; end
      4'd6: begin alu_res = a_val | b_val; alu_wr = 1'b1; alu_fl = 1'b1; end
      4'd7: begin alu_res = a_val ^ b_val; alu_wr = 1'b1; alu_fl = 1'b1; end
      4'd8: begin alu_res = ~b_val;        alu_wr = 1'b1; alu_fl = 1'b1; end
      4'd9: begin
        alu_res = shl_ext[DW-1:0];
        c_new   = shl_ext[DW];
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      4'd10: begin
        alu_res = shr_ext[DW:1];
        c_new   = shr_ext[0];
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
      4'd11: begin
        alu_res = sar_ext[DW:1];
        c_new   = sar_ext[0];
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
      end
`ifdef EXU_MUL_EN
      4'd13: mul_start = 1'b1;
`endif
      default: ;
    endcase
    alu_flags = {v_new, c_new, alu_res[DW-1], (alu_res == '0)};
  end

`ifdef EXU_MUL_EN
  // ---------------------------------------------------------------------------
  // Iterative multiplier: one multiplier bit per cycle, DW cycles in MUL.
  // The last partial product is folded in combinationally so the result is
  // written on the final MUL edge without an extra cycle.
  // ---------------------------------------------------------------------------
  localparam int CW = $clog2(DW);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] acc_reg;
  logic [DW-1:0] mcand_reg;
  logic [DW-1:0] mplier_reg;
  logic [AW-1:0] mul_rd_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      mul_rd_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE) begin
        if (accept && mul_start) begin
          acc_reg    <= '0;
          mcand_reg  <= a_val;
          mplier_reg <= b_val;
          cnt_reg    <= '0;
          mul_rd_reg <= op_rd;
        end
      end else begin
        acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    op_ready   = 1'b0;
    mul_done   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        op_ready = rst_n;
        if (op_valid && rst_n && mul_start) state_next = S_MUL;
      end
      S_MUL: begin
        if (cnt_reg == CW'(DW - 1)) begin
          mul_done   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mul_final = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mul_rd    = mul_rd_reg;
`else
  assign op_ready  = rst_n;
  assign mul_done  = 1'b0;
  assign mul_final = '0;
  assign mul_rd    = '0;
`endif

  // A finishing multiply and an accepted op are mutually exclusive because
  // op_ready is low for the whole MUL state.
  always_comb begin
    wr_en   = (accept && alu_wr) || mul_done;
    wr_idx  = mul_done ? mul_rd : op_rd;
    wr_data = mul_done ? mul_final : alu_res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) reg_file[i] <= '0;
    end else if (wr_en && (wr_idx != '0)) begin
      reg_file[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_rd_reg    <= '0;
    end else begin
      res_valid_reg <= 1'b0;
      if (mul_done) begin
        res_valid_reg <= 1'b1;
        res_data_reg  <= mul_final;
        res_rd_reg    <= mul_rd;
        flags_reg     <= {1'b0, 1'b0, mul_final[DW-1], (mul_final == '0)};
      end else if (accept) begin
        if (alu_wr) begin
          res_valid_reg <= 1'b1;
          res_data_reg  <= alu_res;
          res_rd_reg    <= op_rd;
        end
        if (alu_fl) flags_reg <= alu_flags;
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_rd    = res_rd_reg;
  assign flags     = flags_reg;

  // FV kept for readability of the flag layout
  logic unused_fv;
  assign unused_fv = flags_reg[FV];

endmodule

// File: tb/tb_exu.sv
module tb_exu;

`ifdef EXU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [2:0]  op_rd;
  logic [2:0]  op_rs;
  logic [15:0] op_imm;
  logic        op_use_imm;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [15:0] mregs [8];
  logic [3:0]  mflags;

  always #5 clk = ~clk;

  exu #(.DW(16), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_rd(op_rd), .op_rs(op_rs), .op_imm(op_imm),
    .op_use_imm(op_use_imm), .res_valid(res_valid), .res_data(res_data),
    .res_rd(res_rd), .flags(flags)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sv16(input longint x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic bit ovf16(input longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    mflags = 4'h0;
  endtask

  // Architectural model: computes result/strobe/flags from plain arithmetic
  // and updates the reference registers and flags.
  task automatic model(input logic [3:0] code, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [15:0] imm, input logic use_imm,
                       output logic [15:0] r, output logic vld, output logic [3:0] f);
    longint a, b, s, cin, sa;
    int n;
    logic cf, vf, upd;
    a   = (rd == 0) ? 0 : longint'(mregs[rd]);
    b   = use_imm ? longint'(imm) : ((rs == 0) ? 0 : longint'(mregs[rs]));
    cin = longint'(mflags[2]);
    n   = int'(b % 16);
    r = 16'h0; vld = 1'b0; cf = 1'b0; vf = 1'b0; upd = 1'b1;
    case (code)
      4'd0: begin r = 16'(b); vld = 1'b1; upd = 1'b0; end
      4'd1, 4'd2: begin
        if (code == 4'd1) cin = 0;
        s = a + b + cin;
        r = 16'(s % 65536); cf = (s > 65535); vf = ovf16(sv16(a) + sv16(b) + cin);
        vld = 1'b1;
      end
      4'd3, 4'd4, 4'd12: begin
        if (code != 4'd4) cin = 0;
        s = a - b - cin;
        r = 16'((s + 131072) % 65536); cf = (s < 0); vf = ovf16(sv16(a) - sv16(b) - cin);
        vld = (code != 4'd12);
      end
      4'd5: begin r = 16'(a & b); vld = 1'b1; end
      4'd6: begin r = 16'(a | b); vld = 1'b1; end
      4'd7: begin r = 16'(a ^ b); vld = 1'b1; end
      4'd8: begin r = 16'(65535 - b); vld = 1'b1; end
      4'd9: begin
        r = 16'((a << n) % 65536); cf = (n == 0) ? 1'b0 : 1'(a >> (16 - n)); vld = 1'b1;
      end
      4'd10: begin
        r = 16'(a >> n); cf = (n == 0) ? 1'b0 : 1'(a >> (n - 1)); vld = 1'b1;
      end
      4'd11: begin
        sa = sv16(a);
        r = 16'(sa >>> n); cf = (n == 0) ? 1'b0 : 1'(a >> (n - 1)); vld = 1'b1;
      end
      4'd13: begin
        if (MUL_EN) begin r = 16'((a * b) % 65536); vld = 1'b1; end
        else upd = 1'b0;
      end
      default: upd = 1'b0;
    endcase
    f = upd ? {vf, cf, r[15], (r == 16'h0)} : mflags;
    if (vld && rd != 0) mregs[rd] = r;
    mflags = f;
  endtask

  // Present one op for one accept edge and check the outcome in the
  // following cycle (or after the full multiply).
  task automatic issue(input logic [3:0] code, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [15:0] imm, input logic use_imm, input string tag);
    logic [15:0] er;
    logic        ev;
    logic [3:0]  ef;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_code = code; op_rd = rd; op_rs = rs; op_imm = imm; op_use_imm = use_imm;
    model(code, rd, rs, imm, use_imm, er, ev, ef);
    @(posedge clk); #1;
    if (MUL_EN && code == 4'd13) begin
      for (int k = 0; k < 16; k++) begin
        chk({tag, ".mul_busy_valid"}, 32'(res_valid), 32'd0);
        chk({tag, ".mul_busy_ready"}, 32'(op_ready), 32'd0);
        @(negedge clk);
        // junk op held by producer must be ignored
        op_code = 4'($urandom); op_rd = 3'($urandom); op_rs = 3'($urandom);
        op_imm = 16'($urandom); op_use_imm = 1'($urandom);
        @(posedge clk); #1;
      end
      chk({tag, ".mul_ready_back"}, 32'(op_ready), 32'd1);
    end
    chk({tag, ".valid"}, 32'(res_valid), 32'(ev));
    if (ev) begin
      chk({tag, ".data"}, 32'(res_data), 32'(er));
      chk({tag, ".rd"}, 32'(res_rd), 32'(rd));
    end
    chk({tag, ".flags"}, 32'(flags), 32'(ef));
    $display("op code=%0d rd=%0d rs=%0d imm=0x%04h ui=%0d -> valid=%0d data=0x%04h flags=%04b",
             code, rd, rs, imm, use_imm, res_valid, res_data, flags);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".idle_valid"}, 32'(res_valid), 32'd0);
  endtask

  function automatic logic [15:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_code = 4'h0; op_rd = 3'h0; op_rs = 3'h0;
    op_imm = 16'h0; op_use_imm = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", 32'(res_valid), 32'd0);
    chk("rst.data",  32'(res_data),  32'd0);
    chk("rst.rd",    32'(res_rd),    32'd0);
    chk("rst.flags", 32'(flags),     32'd0);
    chk("rst.ready", 32'(op_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MOV r1,#0x1234
    issue(4'd0, 3'd1, 3'd0, 16'h1234, 1'b1, "mov_imm");
    chk("mov_imm.const_flags", 32'(flags), 32'd0);

    // ADD wrap to zero, then signed overflow
    issue(4'd0, 3'd1, 3'd0, 16'hFFFF, 1'b1, "mov_ffff");
    issue(4'd1, 3'd1, 3'd0, 16'h0001, 1'b1, "add_wrap");
    chk("add_wrap.const", 32'({res_data, flags}), 32'({16'h0000, 4'b0101}));
    issue(4'd0, 3'd2, 3'd0, 16'h7FFF, 1'b1, "mov_7fff");
    issue(4'd1, 3'd2, 3'd0, 16'h0001, 1'b1, "add_ovf");
    chk("add_ovf.const", 32'({res_data, flags}), 32'({16'h8000, 4'b1010}));

    // CMP leaves r1 alone, borrow set
    issue(4'd0, 3'd1, 3'd0, 16'h0005, 1'b1, "mov_5");
    issue(4'd12, 3'd1, 3'd0, 16'h0007, 1'b1, "cmp");
    chk("cmp.const_flags", 32'(flags), 32'(4'b0110));
    issue(4'd0, 3'd3, 3'd1, 16'h0000, 1'b0, "read_r1");
    chk("read_r1.const", 32'(res_data), 32'h5);

    // r0 ignores writes but still strobes
    issue(4'd0, 3'd0, 3'd0, 16'h0055, 1'b1, "mov_r0");
    issue(4'd0, 3'd3, 3'd0, 16'h0000, 1'b0, "read_r0");
    chk("read_r0.const", 32'(res_data), 32'h0);

    // SHL carry out
    issue(4'd0, 3'd1, 3'd0, 16'h8001, 1'b1, "mov_8001");
    issue(4'd9, 3'd1, 3'd0, 16'h0001, 1'b1, "shl");
    chk("shl.const", 32'({res_data, flags}), 32'({16'h0002, 4'b0100}));

    // NOP keeps flags
    issue(4'd14, 3'd2, 3'd1, 16'h0000, 1'b0, "nop");
    idle("gap");

    if (MUL_EN) begin
      issue(4'd0, 3'd1, 3'd0, 16'h0102, 1'b1, "mov_0102");
      issue(4'd0, 3'd2, 3'd0, 16'h0304, 1'b1, "mov_0304");
      issue(4'd13, 3'd1, 3'd2, 16'h0000, 1'b0, "mul");
      chk("mul.const", 32'(res_data), 32'h0A08);

      // reset in the middle of a multiply
      @(negedge clk);
      op_valid = 1'b1; op_code = 4'd13; op_rd = 3'd1; op_rs = 3'd2; op_use_imm = 1'b0;
      @(posedge clk);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; op_valid = 1'b0;
      @(posedge clk); #1;
      chk("mulrst.valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 20; k++) begin
        @(posedge clk); #1;
        chk("mulrst.no_result", 32'(res_valid), 32'd0);
      end
      issue(4'd0, 3'd3, 3'd1, 16'h0000, 1'b0, "mulrst_read_r1");
      chk("mulrst_read_r1.const", 32'(res_data), 32'h0);
    end else begin
      issue(4'd13, 3'd1, 3'd2, 16'h0000, 1'b0, "mul_as_nop");
      chk("mul_as_nop.ready", 32'(op_ready), 32'd1);
    end

    // randomized back-to-back ops
    for (int t = 0; t < 300; t++) begin
      issue(4'($urandom), 3'($urandom), 3'($urandom), rand_imm(), 1'($urandom), "rand");
      if ($urandom_range(0, 9) == 0) idle("rand_gap");
    end

    // read back the whole register file
    for (int i = 0; i < 8; i++) begin
      issue(4'd0, 3'd7, 3'(i), 16'h0000, 1'b0, "readback");
    end
    idle("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
